// File: rtl/oam_scan_scheduler_if.sv
// ---------------------------------------------------------------------------
// oam_scan_scheduler_if
//   CPU/bus access channel into the OAM scan scheduler.
//   master modport : the bus side (issues requests, receives grant/read data)
//   slave  modport : the scheduler side (grants requests, returns read data)
//   Signals:
//     cpu_req    request, held by the master until cpu_gnt
//     cpu_we     1 = write, 0 = read
//     cpu_addr   OAM entry address
//     cpu_wdata  write data
//     cpu_gnt    request accepted this cycle
//     cpu_rdata  read data (valid with cpu_rvalid)
//     cpu_rvalid read data strobe, one cycle after a read grant
// ---------------------------------------------------------------------------
interface oam_scan_scheduler_if #(
    parameter int ADDR_W = 6
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt;
    logic [31:0]       cpu_rdata;
    logic              cpu_rvalid;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata, cpu_rvalid
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata, cpu_rvalid
    );
endinterface

// File: rtl/oam_scan_scheduler.sv
// ---------------------------------------------------------------------------
// oam_scan_scheduler
//   Owns the single-port OAM RAM. When the beam reaches sx == H_ACTIVE it
//   scans all OAM_ENTRIES entries for the next visible line and streams them
//   to the line preparer; outside of a scan the CPU/bus gets the RAM.
//
//   Ports:
//     clk, reset       clock, synchronous active-high reset
//     sx, sy           beam position
//     cpu              CPU access channel (oam_scan_scheduler_if.slave)
//     oam_addr/we/wdata, oam_rdata
//                      OAM RAM port, read data has 1-cycle latency
//     scan_start       1-cycle pulse when a scan begins
//     scan_line        line being prepared
//     scan_valid/scan_index/scan_data
//                      streamed OAM entries
//     buffer_full      preparer requests an early end of the scan
//     scan_done        1-cycle pulse at the end of a scan
//     overrun          sticky: trigger seen while a scan was still running
//
//   Optional feature macro: OAM_CPU_READBACK_EN
//     defined   : CPU reads return data on cpu_rdata/cpu_rvalid
//     undefined : CPU reads are granted but cpu_rdata/cpu_rvalid stay 0
// ---------------------------------------------------------------------------
module oam_scan_scheduler #(
    parameter int OAM_ENTRIES = 64,
    parameter int ADDR_W      = 6,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    oam_scan_scheduler_if.slave cpu,
    output logic [ADDR_W-1:0] oam_addr,
    output logic              oam_we,
    output logic [31:0]       oam_wdata,
    input  logic [31:0]       oam_rdata,
    output logic              scan_start,
    output logic [9:0]        scan_line,
    output logic              scan_valid,
    output logic [ADDR_W-1:0] scan_index,
    output logic [31:0]       scan_data,
    input  logic              buffer_full,
    output logic              scan_done,
    output logic              overrun
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OAM_ENTRIES - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              scan_start_reg;
    logic [9:0]        scan_line_reg;
    logic              scan_valid_reg;
    logic [ADDR_W-1:0] scan_index_reg;
    logic              scan_done_reg;
    logic              overrun_reg;

    logic       trigger;
    logic       trigger_valid;
    logic [9:0] next_line;
    logic       cpu_gnt_int;

    assign trigger       = (sx == 10'(H_ACTIVE));
    assign next_line     = (sy == 10'(V_TOTAL - 1)) ? 10'd0 : sy + 10'd1;
    assign trigger_valid = trigger && (next_line < 10'(V_ACTIVE));

    // A scan trigger wins over the CPU in the same cycle; the grant is also
    // held off while reset is asserted so no write slips through.
    assign cpu_gnt_int = (state_reg == IDLE) && cpu.cpu_req && !trigger_valid && !reset;
    assign cpu.cpu_gnt = cpu_gnt_int;

    always_comb begin
        oam_addr  = '0;
        oam_we    = 1'b0;
        oam_wdata = '0;
        if (cpu_gnt_int) begin
            oam_addr  = cpu.cpu_addr;
            oam_we    = cpu.cpu_we;
            oam_wdata = cpu.cpu_wdata;
        end else if (state_reg == SCAN) begin
            oam_addr = addr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            scan_start_reg <= 1'b0;
            scan_line_reg  <= '0;
            scan_valid_reg <= 1'b0;
            scan_index_reg <= '0;
            scan_done_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            scan_start_reg <= 1'b0;
            scan_done_reg  <= 1'b0;
            scan_valid_reg <= 1'b0;
            if (state_reg != IDLE && trigger_valid) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (trigger_valid) begin
                        state_reg      <= SCAN;
                        scan_line_reg  <= next_line;
                        scan_start_reg <= 1'b1;
                        addr_reg       <= '0;
                    end
                end
                SCAN: begin
                    if (buffer_full) begin
                        // The read issued this cycle is dropped.
                        state_reg     <= IDLE;
                        scan_done_reg <= 1'b1;
                    end else begin
                        // Data for this address arrives next cycle.
                        scan_valid_reg <= 1'b1;
                        scan_index_reg <= addr_reg;
                        if (addr_reg == LAST_ADDR) begin
                            state_reg <= DRAIN;
                        end else begin
                            addr_reg <= addr_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Last entry is on scan_data this cycle.
                    state_reg     <= IDLE;
                    scan_done_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign scan_start = scan_start_reg;
    assign scan_line  = scan_line_reg;
    assign scan_valid = scan_valid_reg;
    assign scan_index = scan_index_reg;
    assign scan_data  = scan_valid_reg ? oam_rdata : 32'd0;
    assign scan_done  = scan_done_reg;
    assign overrun    = overrun_reg;

`ifdef OAM_CPU_READBACK_EN
    logic cpu_rvalid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rvalid_reg <= 1'b0;
        end else begin
            cpu_rvalid_reg <= cpu_gnt_int && !cpu.cpu_we;
        end
    end

    assign cpu.cpu_rvalid = cpu_rvalid_reg;
    assign cpu.cpu_rdata  = cpu_rvalid_reg ? oam_rdata : 32'd0;
`else
    assign cpu.cpu_rvalid = 1'b0;
    assign cpu.cpu_rdata  = 32'd0;
`endif

endmodule

// File: tb/tb_oam_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_oam_scan_scheduler
//   Directed scenarios followed by randomized traffic. A behavioural model
//   tracks, in absolute cycle numbers, when the current scan was triggered
//   and when it ended, and derives every expected output from that.
// ---------------------------------------------------------------------------
module tb_oam_scan_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  sx, sy;
    logic [5:0]  oam_addr;
    logic        oam_we;
    logic [31:0] oam_wdata;
    logic [31:0] oam_rdata;
    logic        scan_start;
    logic [9:0]  scan_line;
    logic        scan_valid;
    logic [5:0]  scan_index;
    logic [31:0] scan_data;
    logic        buffer_full;
    logic        scan_done;
    logic        overrun;

    oam_scan_scheduler_if #(.ADDR_W(6)) bus ();

    oam_scan_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .sx         (sx),
        .sy         (sy),
        .cpu        (bus.slave),
        .oam_addr   (oam_addr),
        .oam_we     (oam_we),
        .oam_wdata  (oam_wdata),
        .oam_rdata  (oam_rdata),
        .scan_start (scan_start),
        .scan_line  (scan_line),
        .scan_valid (scan_valid),
        .scan_index (scan_index),
        .scan_data  (scan_data),
        .buffer_full(buffer_full),
        .scan_done  (scan_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // OAM RAM with registered read
    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (oam_we) ram[oam_addr] <= oam_wdata;
        oam_rdata <= ram[oam_addr];
    end

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] model_mem [64];
    bit          m_active = 0;
    longint      m_t0 = 0;      // cycle in which the scan trigger was sampled
    longint      m_e  = -1;     // cycle in which buffer_full ended it, -1 = none
    logic [9:0]  m_line = 0;
    bit          m_over = 0;
    bit          m_rv_pend = 0;
    logic [31:0] m_rv_data = 0;

    task automatic model_step();
        longint c, done_c, idx;
        bit busy, exp_start, exp_valid, exp_done, tv, exp_gnt;
        int nxt;
        c      = cyc;
        done_c = (m_e >= 0) ? m_e + 1 : m_t0 + 66;
        busy      = m_active && c >= m_t0 + 1 && c < done_c;
        exp_start = m_active && c == m_t0 + 1;
        exp_valid = m_active && c >= m_t0 + 2 && c <= m_t0 + 65 && (m_e < 0 || c <= m_e);
        exp_done  = m_active && c == done_c;
        idx       = c - m_t0 - 2;
        nxt       = (int'(sy) == 524) ? 0 : int'(sy) + 1;
        tv        = (sx == 10'd640) && nxt < 480;
        exp_gnt   = !busy && bus.cpu_req && !tv && !reset;

        check("scan_start", 64'(scan_start), 64'(exp_start));
        check("scan_valid", 64'(scan_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("scan_index", 64'(scan_index), 64'(idx));
            check("scan_data", 64'(scan_data), 64'(model_mem[idx[5:0]]));
        end
        check("scan_done", 64'(scan_done), 64'(exp_done));
        check("scan_line", 64'(scan_line), 64'(m_line));
        check("overrun", 64'(overrun), 64'(m_over));
        check("cpu_gnt", 64'(bus.cpu_gnt), 64'(exp_gnt));
        if (exp_gnt) begin
            check("gnt_addr", 64'(oam_addr), 64'(bus.cpu_addr));
            check("gnt_we", 64'(oam_we), 64'(bus.cpu_we));
            if (bus.cpu_we) check("gnt_wdata", 64'(oam_wdata), 64'(bus.cpu_wdata));
        end else begin
            check("oam_we_idle", 64'(oam_we), 64'd0);
        end
        if (busy && c <= m_t0 + 64) check("scan_addr", 64'(oam_addr), 64'(c - m_t0 - 1));
`ifdef OAM_CPU_READBACK_EN
        check("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(m_rv_pend));
        if (m_rv_pend) check("cpu_rdata", 64'(bus.cpu_rdata), 64'(m_rv_data));
`else
        check("cpu_rvalid_off", 64'(bus.cpu_rvalid), 64'd0);
        check("cpu_rdata_off", 64'(bus.cpu_rdata), 64'd0);
`endif

        if (reset) begin
            m_active  = 0;
            m_line    = 0;
            m_over    = 0;
            m_rv_pend = 0;
        end else begin
            m_rv_pend = exp_gnt && !bus.cpu_we;
            m_rv_data = model_mem[bus.cpu_addr];
            if (exp_gnt && bus.cpu_we) model_mem[bus.cpu_addr] = bus.cpu_wdata;
            if (busy && tv) m_over = 1;
            if (busy && buffer_full && m_e < 0) m_e = c;
            if (!busy && tv) begin
                m_active = 1;
                m_t0     = c;
                m_e      = -1;
                m_line   = 10'(nxt);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input longint c);
        while (cyc < c) step();
    endtask

    task automatic trig(input int line, output longint t);
        t  = cyc;
        sy = 10'(line);
        sx = 10'd640;
        step();
        sx = 10'd100;
    endtask

    task automatic cpu_access(input bit we, input logic [5:0] a, input logic [31:0] d, output longint g);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        g = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cpu_gnt) begin
                g = cyc;
                break;
            end
            step();
        end
        step();
        bus.cpu_req = 1'b0;
        tests++;
        if (g < 0) begin
            failed++;
            $display("[TB] FAIL cpu_gnt_timeout: no grant within 200 cycles (cycle %0d)", cyc);
        end
    endtask

    initial begin
        longint t, g;
        bit gnt_seen;
        for (int i = 0; i < 64; i++) begin
            ram[i]       = 32'(i + 32'h100);
            model_mem[i] = 32'(i + 32'h100);
        end
        reset = 1'b1; sx = 10'd0; sy = 10'd0; buffer_full = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("lit_reset_valid", 64'(scan_valid), 64'd0);
        check("lit_reset_line", 64'(scan_line), 64'd0);
        check("lit_reset_overrun", 64'(overrun), 64'd0);
        step();

        // Basic scan, sy=15
        trig(15, t);
        @(negedge clk);
        check("lit_basic_start", 64'(scan_start), 64'd1);
        check("lit_basic_line", 64'(scan_line), 64'd16);
        step();
        wait_until(t + 7);
        @(negedge clk);
        check("lit_basic_idx5", 64'(scan_index), 64'd5);
        check("lit_basic_data5", 64'(scan_data), 64'h105);
        step();
        wait_until(t + 66);
        @(negedge clk);
        check("lit_basic_done", 64'(scan_done), 64'd1);
        step();
        wait_until(t + 70);

        // Frame wrap and last visible line
        trig(524, t);
        @(negedge clk);
        check("lit_wrap_line", 64'(scan_line), 64'd0);
        step();
        wait_until(t + 70);
        trig(479, t);
        @(negedge clk);
        check("lit_479_nostart", 64'(scan_start), 64'd0);
        step();
        wait_until(t + 10);

        // CPU blocked by a scan, then read back
        trig(15, t);
        wait_until(t + 5);
        cpu_access(1'b1, 6'd5, 32'hDEADBEEF, g);
        check("lit_blocked_gnt_cycle", 64'(g), 64'(t + 66));
        cpu_access(1'b0, 6'd5, 32'd0, g);
        @(negedge clk);
`ifdef OAM_CPU_READBACK_EN
        check("lit_readback_valid", 64'(bus.cpu_rvalid), 64'd1);
        check("lit_readback_data", 64'(bus.cpu_rdata), 64'hDEADBEEF);
`else
        check("lit_readback_off", 64'(bus.cpu_rvalid), 64'd0);
`endif
        step();

        // Early end on the 10th beat
        trig(40, t);
        wait_until(t + 11);
        buffer_full = 1'b1;
        @(negedge clk);
        check("lit_early_idx9", 64'(scan_index), 64'd9);
        step();
        buffer_full = 1'b0;
        @(negedge clk);
        check("lit_early_done", 64'(scan_done), 64'd1);
        check("lit_early_novalid", 64'(scan_valid), 64'd0);
        step();
        wait_until(t + 20);

        // Trigger beats CPU in the same cycle
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 6'd7; bus.cpu_wdata = 32'h1234_5678;
        sx = 10'd640; sy = 10'd50;
        t = cyc;
        @(negedge clk);
        check("lit_prio_nognt", 64'(bus.cpu_gnt), 64'd0);
        step();
        sx = 10'd100;
        @(negedge clk);
        check("lit_prio_start", 64'(scan_start), 64'd1);
        step();
        cpu_access(1'b1, 6'd7, 32'h1234_5678, g);
        check("lit_prio_gnt_cycle", 64'(g), 64'(t + 66));

        // Reset mid-scan
        trig(15, t);
        wait_until(t + 20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("lit_rst_valid", 64'(scan_valid), 64'd0);
        check("lit_rst_line", 64'(scan_line), 64'd0);
        step();
        wait_until(t + 90);
        trig(100, t);
        wait_until(t + 70);

        // Overrun
        trig(15, t);
        wait_until(t + 30);
        sx = 10'd640; sy = 10'd15;
        step();
        sx = 10'd100;
        @(negedge clk);
        check("lit_overrun_set", 64'(overrun), 64'd1);
        step();
        wait_until(t + 66);
        @(negedge clk);
        check("lit_overrun_done", 64'(scan_done), 64'd1);
        check("lit_overrun_sticky", 64'(overrun), 64'd1);
        step();
        wait_until(t + 100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("lit_overrun_cleared", 64'(overrun), 64'd0);
        step();

        // Randomized traffic
        gnt_seen = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            sx          = ($urandom_range(0, 29) == 0) ? 10'd640 : 10'($urandom_range(0, 799));
            sy          = 10'($urandom_range(0, 524));
            buffer_full = ($urandom_range(0, 39) == 0);
            reset       = ($urandom_range(0, 999) == 0);
            if (bus.cpu_req && gnt_seen) begin
                bus.cpu_req = 1'b0;
            end else if (!bus.cpu_req && $urandom_range(0, 3) == 0) begin
                bus.cpu_req   = 1'b1;
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = 6'($urandom_range(0, 63));
                bus.cpu_wdata = $urandom;
            end
            @(negedge clk);
            gnt_seen = bus.cpu_gnt;
            step();
        end
        reset = 1'b0; bus.cpu_req = 1'b0; sx = 10'd0; buffer_full = 1'b0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/oam_scan_scheduler.md
# oam_scan_scheduler

Sequences and arbitrates the single-port OAM RAM for the sprite pipeline. At the start of horizontal blanking it launches a full 64-entry OAM scan for the next visible line and streams the entries to the line preparer. Outside scans it grants OAM access to CPU/bus requests. It sits between the OAM RAM, the bus interface and `prepare_line`.

## Interface
- `OAM_ENTRIES`, 64: number of OAM entries scanned per line.
- `ADDR_W`, 6: OAM address width; must satisfy `2**ADDR_W >= OAM_ENTRIES`.
- `H_ACTIVE`, 640: the `sx` value that triggers a scan.
- `V_ACTIVE`, 480: visible lines; scans run only for next lines below this.
- `V_TOTAL`, 525: lines per frame; the next line after `V_TOTAL-1` is 0.
- `clk` in 1: single clock; everything is synchronous to the rising edge.
- `reset` in 1: synchronous, active-high.
- `sx`, `sy` in 10 each: current beam position.
- `cpu_req` in 1: CPU access request, held until granted.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in 32: CPU write data.
- `cpu_gnt` out 1: access accepted this cycle.
- `cpu_rdata` out 32: CPU read data.
- `cpu_rvalid` out 1: `cpu_rdata` is valid.
- `oam_addr` out ADDR_W: RAM address.
- `oam_we` out 1: RAM write enable.
- `oam_wdata` out 32: RAM write data.
- `oam_rdata` in 32: RAM read data, 1-cycle latency.
- `scan_start` out 1: 1-cycle pulse that clears the preparer.
- `scan_line` out 10: line being prepared.
- `scan_valid` out 1: `scan_data`/`scan_index` are valid.
- `scan_index` out ADDR_W: OAM index of `scan_data`.
- `scan_data` out 32: OAM entry.
- `buffer_full` in 1: preparer needs no more entries.
- `scan_done` out 1: 1-cycle pulse when the scan ends.
- `overrun` out 1: sticky error flag.

## Operation
- States are IDLE, SCAN and DRAIN.
- **Trigger:** `sx == H_ACTIVE`. Then `next = (sy == V_TOTAL-1) ? 0 : sy+1`. A scan runs only if `next < V_ACTIVE`.
- **IDLE → SCAN on a valid trigger:**
  - register `scan_line <= next`;
  - pulse `scan_start`;
  - clear the address counter to 0.
- **SCAN:**
  - `oam_addr` = counter, incrementing by 1 each cycle from 0 to `OAM_ENTRIES-1`.
  - After the last address, go to DRAIN.
- **DRAIN:** one cycle to collect the last read data, then pulse `scan_done` and return to IDLE.
- **Scan data:** `scan_valid` is the 1-cycle-delayed issue strobe. `scan_index` is the delayed address. `scan_data = oam_rdata`.
- **Early end:** `buffer_full` sampled high in SCAN or DRAIN causes:
  - no further `scan_valid` (the in-flight read is discarded);
  - `scan_done` pulses the next cycle;
  - return to IDLE.
- **CPU arbitration (combinational in IDLE):** `cpu_gnt = (state==IDLE) & cpu_req & ~trigger_valid`. When granted:
  - `oam_addr = cpu_addr`;
  - `oam_we = cpu_we`;
  - `oam_wdata = cpu_wdata`.
- **Priority:** a scan trigger beats the CPU on the same cycle. The CPU gets no grant in SCAN or DRAIN.
- **Overrun:** a trigger while not in IDLE sets `overrun`. The current scan continues. `overrun` clears only on reset.
- **Reset values:** all outputs 0, state IDLE, counters 0. Reset mid-scan aborts the scan with no `scan_done`.

## Timing
- Trigger sampled in cycle T: `scan_start` = 1 and `oam_addr` = 0 in T+1.
- `oam_addr` = k in cycle T+1+k.
- `scan_valid` is high in T+2..T+65, with `scan_index` = 0..63.
- `scan_done` pulses in T+66, with IDLE from T+66. The earliest CPU grant is T+66.
- A full scan occupies 65 cycles of the 800-cycle line.
- CPU read granted in cycle G: `cpu_rvalid` = 1 in G+1 with the read data.
- CPU write granted in cycle G: the RAM is written at the end of G.
- `buffer_full` high in cycle C: `scan_valid` = 0 from C+1, `scan_done` in C+1.

## Configuration
- `OAM_CPU_READBACK_EN` defined:
  - CPU reads return data through `cpu_rdata`/`cpu_rvalid`.
- `OAM_CPU_READBACK_EN` undefined:
  - CPU reads are still granted, but no response is produced;
  - `cpu_rvalid` and `cpu_rdata` are tied to 0;
  - writes are unaffected.

## Test plan
- **Basic scan:** RAM[i]=i+0x100, `sy`=15, `sx` set to 640 in cycle T → `scan_start` in T+1 with `scan_line`=16; 64 `scan_valid` beats, index i carrying i+0x100; `scan_done` in T+66.
- **Frame boundaries:**
  - `sy`=524, `sx`=640 → `scan_line`=0.
  - `sy`=479, `sx`=640 → no `scan_start`, no `scan_valid`.
- **CPU blocked by scan:** CPU write (addr 5, data 0xDEADBEEF) requested at T+5 → `cpu_gnt` = 0 until T+66, granted at T+66. A following read of addr 5 gives `cpu_rvalid` with 0xDEADBEEF one cycle after its grant.
- **Early end and priority:**
  - `buffer_full` raised alongside the 10th `scan_valid` → no further `scan_valid`, `scan_done` the next cycle, IDLE.
  - `cpu_req` and a trigger in the same cycle → `cpu_gnt` = 0, the scan starts.
- **Reset mid-scan:** `reset` at T+20 → all outputs 0 the next cycle, no `scan_done`; the next trigger scans normally.
- **Overrun:** a forced trigger at T+30 → `overrun` = 1 and stays 1; the scan still ends at T+66; `overrun` is cleared only by reset.
